// File: rtl/nios2_mul_result_combine.sv
// Final adder stage of the CPU multiplier: folds four 16x16 partial products
// into the 64-bit product over a 2-stage enable-gated pipeline and selects the writeback word.
module nios2_mul_result_combine #(
    parameter int unsigned RESULT_W = 32,
    parameter bit          REG_OUT  = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                M_en,
    input  logic                M_flush,
    input  logic                M_mul_valid,
    input  logic                M_mul_hi,
    input  logic                M_mul_src1_signed,
    input  logic                M_mul_src2_signed,
    input  logic [31:0]         M_mul_cell_p1,
    input  logic [31:0]         M_mul_cell_p2,
    input  logic [31:0]         M_mul_cell_p3,
    input  logic [31:0]         M_mul_cell_p4,
    output logic [RESULT_W-1:0] W_mul_result,
    output logic                W_mul_result_valid,
    output logic                W_mul_busy
);

    localparam int unsigned PP_W   = 32;
    localparam int unsigned MID_W  = PP_W + 2;
    localparam int unsigned PROD_W = 2 * PP_W;

    if (RESULT_W != 32) begin : g_bad_result_w
        $error("nios2_mul_result_combine: RESULT_W must be 32");
    end

    logic [MID_W-1:0]  w_p2_ext;
    logic [MID_W-1:0]  w_p3_ext;
    logic [MID_W-1:0]  w_mid;
    logic [PROD_W-1:0] w_mid_ext;
    logic [PROD_W-1:0] w_prod;
    logic [PP_W-1:0]   w_sel;

    logic [MID_W-1:0]  r_mid;
    logic [PROD_W-1:0] r_lo64;
    logic              r_hi1;
    logic              r_v1;

    // Cross terms: 33-bit sign/zero extension, then one more sign bit for the carry.
    assign w_p2_ext = {{2{M_mul_src2_signed & M_mul_cell_p2[PP_W-1]}}, M_mul_cell_p2};
    assign w_p3_ext = {{2{M_mul_src1_signed & M_mul_cell_p3[PP_W-1]}}, M_mul_cell_p3};
    assign w_mid    = w_p2_ext + w_p3_ext;

    // Stage 1: cross-term sum plus the outer products packed as one 64-bit word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mid  <= '0;
            r_lo64 <= '0;
            r_hi1  <= 1'b0;
            r_v1   <= 1'b0;
        end else begin
            if (M_en) begin
                r_mid  <= w_mid;
                r_lo64 <= {M_mul_cell_p4, M_mul_cell_p1};
                r_hi1  <= M_mul_hi;
            end
            if (M_flush) begin
                r_v1 <= 1'b0;
            end else if (M_en) begin
                r_v1 <= M_mul_valid;
            end
        end
    end

    assign w_mid_ext = {{(PROD_W - MID_W){r_mid[MID_W-1]}}, r_mid};
    assign w_prod    = r_lo64 + (w_mid_ext << 16);
    assign w_sel     = r_hi1 ? w_prod[PROD_W-1:PP_W] : w_prod[PP_W-1:0];

    if (REG_OUT) begin : g_reg_out
        logic [RESULT_W-1:0] r_result;
        logic                r_v2;

        // Stage 2: the result only loads for a live op, so it holds across bubbles.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_result <= '0;
                r_v2     <= 1'b0;
            end else begin
                if (M_en && r_v1 && !M_flush) begin
                    r_result <= RESULT_W'(w_sel);
                end
                if (M_flush) begin
                    r_v2 <= 1'b0;
                end else if (M_en) begin
                    r_v2 <= r_v1;
                end
            end
        end

        assign W_mul_result       = r_result;
        assign W_mul_result_valid = r_v2;
        assign W_mul_busy         = r_v1 | r_v2;
    end else begin : g_comb_out
        assign W_mul_result       = RESULT_W'(w_sel);
        assign W_mul_result_valid = r_v1;
        assign W_mul_busy         = r_v1;
    end

endmodule

// File: tb/tb_nios2_mul_result_combine.sv
// Bench for nios2_mul_result_combine: partial products built from operands as the
// multiplier cell would, results checked against a 64-bit reference through a queue.
module tb_nios2_mul_result_combine;

    logic        clk;
    logic        reset_n;
    logic        M_en;
    logic        M_flush;
    logic        M_mul_valid;
    logic        M_mul_hi;
    logic        M_mul_src1_signed;
    logic        M_mul_src2_signed;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    logic [31:0] M_mul_cell_p4;
    logic [31:0] W_mul_result;
    logic        W_mul_result_valid;
    logic        W_mul_busy;

    nios2_mul_result_combine #(.RESULT_W(32), .REG_OUT(1'b1)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .M_en               (M_en),
        .M_flush            (M_flush),
        .M_mul_valid        (M_mul_valid),
        .M_mul_hi           (M_mul_hi),
        .M_mul_src1_signed  (M_mul_src1_signed),
        .M_mul_src2_signed  (M_mul_src2_signed),
        .M_mul_cell_p1      (M_mul_cell_p1),
        .M_mul_cell_p2      (M_mul_cell_p2),
        .M_mul_cell_p3      (M_mul_cell_p3),
        .M_mul_cell_p4      (M_mul_cell_p4),
        .W_mul_result       (W_mul_result),
        .W_mul_result_valid (W_mul_result_valid),
        .W_mul_busy         (W_mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s1;
        logic        s2;
        logic        hi;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t tbl [NVEC];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic        ev1 = 1'b0;
    logic        ev2 = 1'b0;
    logic [31:0] last_exp = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] pp(input logic [15:0] x, input logic sx,
                                       input logic [15:0] y, input logic sy);
        logic [31:0] xe;
        logic [31:0] ye;
        xe = sx ? {{16{x[15]}}, x} : {16'h0, x};
        ye = sy ? {{16{y[15]}}, y} : {16'h0, y};
        return xe * ye;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic s1,
                                             input logic [31:0] b, input logic s2,
                                             input logic hi);
        logic [63:0] ae;
        logic [63:0] be;
        logic [63:0] pr;
        ae = s1 ? {{32{a[31]}}, a} : {32'h0, a};
        be = s2 ? {{32{b[31]}}, b} : {32'h0, b};
        pr = ae * be;
        return hi ? pr[63:32] : pr[31:0];
    endfunction

    // One clock: drive, advance the expected valid bits, sample 1ns after the edge.
    task automatic cyc(input logic en, input logic fl, input logic vl, input logic hi,
                       input logic s1, input logic s2, input logic [31:0] a,
                       input logic [31:0] b, input logic use_exp, input logic [31:0] exp);
        logic nv1;
        logic nv2;
        logic adv;
        M_en              = en;
        M_flush           = fl;
        M_mul_valid       = vl;
        M_mul_hi          = hi;
        M_mul_src1_signed = s1;
        M_mul_src2_signed = s2;
        M_mul_cell_p1     = pp(a[15:0],  1'b0, b[15:0],  1'b0);
        M_mul_cell_p2     = pp(a[15:0],  1'b0, b[31:16], s2);
        M_mul_cell_p3     = pp(a[31:16], s1,   b[15:0],  1'b0);
        M_mul_cell_p4     = pp(a[31:16], s1,   b[31:16], s2);
        if (en && vl && !fl)
            exp_q.push_back(use_exp ? exp : ref_word(a, s1, b, s2, hi));
        nv1 = fl ? 1'b0 : (en ? vl  : ev1);
        nv2 = fl ? 1'b0 : (en ? ev1 : ev2);
        adv = en && !fl && ev1;
        @(posedge clk);
        #1;
        ev1 = nv1;
        ev2 = nv2;
        if (fl)
            exp_q.delete();
        if (adv) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard: valid result 0x%08h with nothing expected at %0t",
                         W_mul_result, $time);
            end else begin
                last_exp = exp_q.pop_front();
            end
        end
        chk("valid", 32'(W_mul_result_valid), 32'(ev2));
        chk("busy", 32'(W_mul_busy), 32'(ev1 | ev2));
        if (ev2)
            chk("result", W_mul_result, last_exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic op(input logic hi, input logic s1, input logic s2,
                      input logic [31:0] a, input logic [31:0] b);
        cyc(1'b1, 1'b0, 1'b1, hi, s1, s2, a, b, 1'b0, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
        tbl[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
        tbl[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000};
        tbl[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000001};
        tbl[4]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
        tbl[5]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
        tbl[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
        tbl[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
        tbl[8]  = '{32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF};
        tbl[9]  = '{32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFE};
        tbl[10] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h00000001};
        tbl[11] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b0, 32'h00000000};
        tbl[12] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'hC0000000};
        tbl[13] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h80000000};

        reset_n = 1'b0;
        M_en = 1'b0; M_flush = 1'b0; M_mul_valid = 1'b0; M_mul_hi = 1'b0;
        M_mul_src1_signed = 1'b0; M_mul_src2_signed = 1'b0;
        M_mul_cell_p1 = '0; M_mul_cell_p2 = '0; M_mul_cell_p3 = '0; M_mul_cell_p4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(W_mul_result_valid), 32'h0);
        chk("reset_busy", 32'(W_mul_busy), 32'h0);
        chk("reset_result", W_mul_result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Known-answer vectors, issued back to back.
        for (int i = 0; i < NVEC; i++)
            cyc(1'b1, 1'b0, 1'b1, tbl[i].hi, tbl[i].s1, tbl[i].s2, tbl[i].a, tbl[i].b,
                1'b1, tbl[i].exp);
        idle(3);

        // A, B back to back, 3-cycle stall with A valid, then C.
        op(1'b0, 1'b0, 1'b0, 32'h00001234, 32'h00005678);
        op(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 32'h0);
        op(1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0BADC0DE);
        idle(3);

        // Flush while B is in stage 1 and C is presented.
        op(1'b1, 1'b0, 1'b0, 32'h11111111, 32'h22222222);
        op(1'b1, 1'b0, 1'b0, 32'h33333333, 32'h44444444);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55555555, 32'h66666666, 1'b0, 32'h0);
        idle(2);

        // Flush during a stall still clears both stages.
        op(1'b0, 1'b1, 1'b1, 32'h87654321, 32'h0F0F0F0F);
        op(1'b1, 1'b1, 1'b1, 32'h87654321, 32'h0F0F0F0F);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        idle(2);

        // Asynchronous reset pulse mid-stream.
        op(1'b0, 1'b0, 1'b1, 32'h00ABCDEF, 32'hFEDCBA98);
        op(1'b1, 1'b0, 1'b1, 32'h00ABCDEF, 32'hFEDCBA98);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(W_mul_result_valid), 32'h0);
        chk("async_reset_busy", 32'(W_mul_busy), 32'h0);
        chk("async_reset_result", W_mul_result, 32'h0);
        exp_q.delete();
        ev1 = 1'b0;
        ev2 = 1'b0;
        last_exp = 32'h0;
        #4;
        reset_n = 1'b1;
        op(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
        idle(3);

        // Random traffic with stalls and occasional flushes, all signedness combinations.
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, 1'b0, 32'h0);
        end
        idle(4);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
